// File: rtl/jpeg_zigzag_rle_pkg.sv
// Shared definitions for the JPEG zigzag scanner / AC run-length symbolizer.
// Holds the zigzag-to-raster table, the FSM state type and the symbol constants.
package jpeg_pkg;

    localparam int COEF_WIDTH  = 12;
    localparam int BLOCK_DEPTH = 64;

    localparam logic [3:0] ZRL_RUN = 4'd15;

    // Entry k is the raster position visited at zigzag step k.
    localparam logic [5:0] ZIGZAG_TO_RASTER [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [2:0] {
        IDLE,
        DC,
        SCAN,
        EMIT,
        EOB
    } state_t;

endpackage

// File: rtl/jpeg_zigzag_rle_if.sv
// Block-in / symbol-out handshake bundle for jpeg_zigzag_rle.
// The encoder core connects through the slave modport; its environment uses master.
interface jpeg_zigzag_rle_if #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 64
);
    logic                        block_valid;
    logic                        block_ready;
    logic [DATA_WIDTH*DEPTH-1:0] block_768bits;

    logic                  sym_valid;
    logic                  sym_ready;
    logic [3:0]            sym_run;
    logic [DATA_WIDTH-1:0] sym_value;
    logic                  sym_dc;
    logic                  sym_zrl;
    logic                  sym_eob;
    logic                  sym_last;

    modport slave (
        input  block_valid, block_768bits, sym_ready,
        output block_ready, sym_valid, sym_run, sym_value,
               sym_dc, sym_zrl, sym_eob, sym_last
    );

    modport master (
        output block_valid, block_768bits, sym_ready,
        input  block_ready, sym_valid, sym_run, sym_value,
               sym_dc, sym_zrl, sym_eob, sym_last
    );
endinterface

// File: rtl/jpeg_zigzag_rle_lut.sv
// Combinational zigzag-step to raster-position lookup.
module jpeg_zigzag_lut
    import jpeg_pkg::*;
(
    input  logic [5:0] zigzag_idx,
    output logic [5:0] raster_idx
);

    assign raster_idx = ZIGZAG_TO_RASTER[zigzag_idx];

endmodule

// File: rtl/jpeg_zigzag_rle.sv
// Zigzag scanner and AC run-length symbolizer: latches one 8x8 block and emits
// DC, (run,value), ZRL and EOB symbols over a registered valid/ready interface.
module jpeg_zigzag_rle
    import jpeg_pkg::*;
#(
    parameter int DATA_WIDTH = COEF_WIDTH,
    parameter int DEPTH      = BLOCK_DEPTH
) (
    input logic              clock,
    input logic              reset,
    jpeg_zigzag_rle_if.slave bus
);

    state_t state, state_next;

    logic [DATA_WIDTH*DEPTH-1:0] block_reg;
    logic                        load_block;

    logic [5:0]            idx, idx_next;
    logic [5:0]            zrun, zrun_next;
    logic [5:0]            raster_idx;
    logic [DATA_WIDTH-1:0] coef;
    logic                  handshake;

    logic                  sym_valid_q, sym_valid_next;
    logic [3:0]            sym_run_q, sym_run_next;
    logic [DATA_WIDTH-1:0] sym_value_q, sym_value_next;
    logic                  sym_dc_q, sym_dc_next;
    logic                  sym_zrl_q, sym_zrl_next;
    logic                  sym_eob_q, sym_eob_next;
    logic                  sym_last_q, sym_last_next;

    jpeg_zigzag_lut u_lut (
        .zigzag_idx (idx),
        .raster_idx (raster_idx)
    );

    assign coef      = block_reg[raster_idx*DATA_WIDTH +: DATA_WIDTH];
    assign handshake = sym_valid_q && bus.sym_ready;

    assign bus.block_ready = (state == IDLE) && !reset;
    assign bus.sym_valid   = sym_valid_q;
    assign bus.sym_run     = sym_run_q;
    assign bus.sym_value   = sym_value_q;
    assign bus.sym_dc      = sym_dc_q;
    assign bus.sym_zrl     = sym_zrl_q;
    assign bus.sym_eob     = sym_eob_q;
    assign bus.sym_last    = sym_last_q;

    // Symbols are built here and registered, so each one appears the cycle after
    // the state that decided it; fields clear once a symbol is consumed.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        zrun_next      = zrun;
        load_block     = 1'b0;
        sym_valid_next = sym_valid_q;
        sym_run_next   = sym_run_q;
        sym_value_next = sym_value_q;
        sym_dc_next    = sym_dc_q;
        sym_zrl_next   = sym_zrl_q;
        sym_eob_next   = sym_eob_q;
        sym_last_next  = sym_last_q;

        case (state)
            IDLE: begin
                if (bus.block_valid) begin
                    load_block     = 1'b1;
                    state_next     = DC;
                    sym_valid_next = 1'b1;
                    sym_run_next   = 4'd0;
                    sym_value_next = bus.block_768bits[DATA_WIDTH-1:0];
                    sym_dc_next    = 1'b1;
                    sym_zrl_next   = 1'b0;
                    sym_eob_next   = 1'b0;
                    sym_last_next  = 1'b0;
                end
            end

            DC: begin
                if (handshake) begin
                    state_next     = SCAN;
                    idx_next       = 6'd1;
                    zrun_next      = 6'd0;
                    sym_valid_next = 1'b0;
                    sym_value_next = '0;
                    sym_dc_next    = 1'b0;
                end
            end

            SCAN: begin
                if (coef == '0) begin
                    if (idx != 6'd63) begin
                        zrun_next = zrun + 6'd1;
                        idx_next  = idx + 6'd1;
                    end else begin
                        // Trailing zeros collapse into EOB; leftover long runs are dropped.
                        state_next     = EOB;
                        sym_valid_next = 1'b1;
                        sym_run_next   = 4'd0;
                        sym_value_next = '0;
                        sym_eob_next   = 1'b1;
                        sym_last_next  = 1'b1;
                    end
                end else if (zrun >= 6'd16) begin
                    state_next     = EMIT;
                    sym_valid_next = 1'b1;
                    sym_run_next   = ZRL_RUN;
                    sym_value_next = '0;
                    sym_zrl_next   = 1'b1;
                    sym_last_next  = 1'b0;
                end else begin
                    state_next     = EMIT;
                    sym_valid_next = 1'b1;
                    sym_run_next   = zrun[3:0];
                    sym_value_next = coef;
                    sym_zrl_next   = 1'b0;
                    sym_last_next  = (idx == 6'd63);
                end
            end

            EMIT: begin
                if (handshake) begin
                    sym_valid_next = 1'b0;
                    sym_run_next   = 4'd0;
                    sym_value_next = '0;
                    sym_zrl_next   = 1'b0;
                    sym_last_next  = 1'b0;
                    // A ZRL rescans the same coefficient with 16 fewer pending zeros.
                    if (sym_zrl_q) begin
                        zrun_next  = zrun - 6'd16;
                        state_next = SCAN;
                    end else if (sym_last_q) begin
                        zrun_next  = 6'd0;
                        idx_next   = 6'd0;
                        state_next = IDLE;
                    end else begin
                        zrun_next  = 6'd0;
                        idx_next   = idx + 6'd1;
                        state_next = SCAN;
                    end
                end
            end

            EOB: begin
                if (handshake) begin
                    state_next     = IDLE;
                    idx_next       = 6'd0;
                    zrun_next      = 6'd0;
                    sym_valid_next = 1'b0;
                    sym_eob_next   = 1'b0;
                    sym_last_next  = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Synchronous reset aborts any block in flight and drops the pending symbol.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            block_reg   <= '0;
            idx         <= 6'd0;
            zrun        <= 6'd0;
            sym_valid_q <= 1'b0;
            sym_run_q   <= 4'd0;
            sym_value_q <= '0;
            sym_dc_q    <= 1'b0;
            sym_zrl_q   <= 1'b0;
            sym_eob_q   <= 1'b0;
            sym_last_q  <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            zrun        <= zrun_next;
            sym_valid_q <= sym_valid_next;
            sym_run_q   <= sym_run_next;
            sym_value_q <= sym_value_next;
            sym_dc_q    <= sym_dc_next;
            sym_zrl_q   <= sym_zrl_next;
            sym_eob_q   <= sym_eob_next;
            sym_last_q  <= sym_last_next;
            if (load_block) begin
                block_reg <= bus.block_768bits;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_zigzag_rle.sv
// Self-checking bench for jpeg_zigzag_rle: table-driven blocks, randomized blocks
// and stalls against a diagonal-walk reference model, plus reset corner cases.
module tb_jpeg_zigzag_rle;

    typedef struct {
        int run;
        int value;
        bit dc;
        bit zrl;
        bit eob;
        bit last;
    } exp_sym_t;

    typedef struct {
        int dc_val;
        int pos0;
        int val0;
        int pos1;
        int val1;
        int exp_syms;
        int exp_zrl;
        bit exp_eob_end;
        int stall_mode;
    } vec_t;

    logic clock = 1'b0;
    logic reset;

    jpeg_zigzag_rle_if bus ();

    jpeg_zigzag_rle dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int coefs [64];
    int zz [64];
    exp_sym_t exp_q [$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Zigzag order derived by walking anti-diagonals of the 8x8 grid.
    task automatic buildZigzag();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int row = hi; row >= lo; row--) begin
                    zz[k] = row * 8 + (s - row);
                    k++;
                end
            end else begin
                for (int row = lo; row <= hi; row++) begin
                    zz[k] = row * 8 + (s - row);
                    k++;
                end
            end
        end
    endtask

    task automatic buildModel();
        int run = 0;
        int c;
        exp_q.delete();
        exp_q.push_back('{0, coefs[0] & 'hFFF, 1'b1, 1'b0, 1'b0, 1'b0});
        for (int k = 1; k < 64; k++) begin
            c = coefs[zz[k]] & 'hFFF;
            if (c == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back('{15, 0, 1'b0, 1'b1, 1'b0, 1'b0});
                    run -= 16;
                end
                exp_q.push_back('{run, c, 1'b0, 1'b0, 1'b0, (k == 63)});
                run = 0;
            end
        end
        if ((coefs[zz[63]] & 'hFFF) == 0)
            exp_q.push_back('{0, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    endtask

    task automatic applyStimulus(input int stall_mode, input bit check_timing,
                                 output int n_syms, output int n_zrl,
                                 output bit eob_end, output int model_syms);
        logic [767:0] blk;
        exp_sym_t e;
        int guard = 0;
        int cyc;
        int stall = 0;
        int eob_cycle = -1;
        bit ready;
        n_syms = 0;
        n_zrl = 0;
        eob_end = 1'b0;
        buildModel();
        model_syms = exp_q.size();
        for (int r = 0; r < 64; r++) blk[12*r +: 12] = coefs[r][11:0];

        @(negedge clock);
        bus.block_768bits = blk;
        bus.block_valid = 1'b1;
        bus.sym_ready = 1'b0;
        while (bus.block_ready !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) begin
            checkOutput("accept_timeout", 0, 1);
            bus.block_valid = 1'b0;
            return;
        end
        @(negedge clock);
        bus.block_valid = 1'b0;
        bus.block_768bits = {24{$urandom()}};
        cyc = 1;
        checkOutput("dc_latency", int'(bus.sym_valid && bus.sym_dc), 1);

        while (exp_q.size() > 0 && cyc < 3000) begin
            ready = 1'b0;
            if (bus.sym_valid === 1'b1) begin
                e = exp_q[0];
                checkOutput("sym_run", int'(bus.sym_run), e.run);
                checkOutput("sym_value", int'(bus.sym_value), e.value);
                checkOutput("sym_dc", int'(bus.sym_dc), int'(e.dc));
                checkOutput("sym_zrl", int'(bus.sym_zrl), int'(e.zrl));
                checkOutput("sym_eob", int'(bus.sym_eob), int'(e.eob));
                checkOutput("sym_last", int'(bus.sym_last), int'(e.last));
                checkOutput("block_ready_busy", int'(bus.block_ready), 0);
                if (e.eob && eob_cycle < 0) eob_cycle = cyc;
                case (stall_mode)
                    0: ready = 1'b1;
                    1: ready = ($urandom_range(0, 2) != 0);
                    default: ready = (stall >= 5);
                endcase
                stall++;
                if (ready) begin
                    void'(exp_q.pop_front());
                    n_syms++;
                    if (e.zrl) n_zrl++;
                    if (e.eob) eob_end = 1'b1;
                    stall = 0;
                end
            end
            bus.sym_ready = ready;
            @(negedge clock);
            cyc++;
        end
        bus.sym_ready = 1'b0;
        if (exp_q.size() != 0) begin
            checkOutput("symbol_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        checkOutput("sym_valid_after_last", int'(bus.sym_valid), 0);
        checkOutput("block_ready_after_last", int'(bus.block_ready), 1);
        if (check_timing) checkOutput("eob_latency", eob_cycle, 65);
    endtask

    task automatic loadVector(input vec_t v);
        for (int r = 0; r < 64; r++) coefs[r] = 0;
        coefs[0] = v.dc_val;
        if (v.pos0 >= 0) coefs[v.pos0] = v.val0;
        if (v.pos1 >= 0) coefs[v.pos1] = v.val1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [8];
        int n_syms, n_zrl, model_syms;
        bit eob_end;

        vecs[0] = '{5,     -1,  0,     -1, 0,  2, 0, 1'b1, 0};
        vecs[1] = '{0,      1,  3,      8, -2, 4, 0, 1'b1, 0};
        vecs[2] = '{0,     19,  7,     -1, 0,  4, 1, 1'b1, 0};
        vecs[3] = '{0,     63,  1,     -1, 0,  5, 3, 1'b0, 0};
        vecs[4] = '{0,     19,  7,     -1, 0,  4, 1, 1'b1, 2};
        vecs[5] = '{-2048, 63, -2048,  -1, 0,  5, 3, 1'b0, 1};
        vecs[6] = '{0,      1,  1,     63, 2,  6, 3, 1'b0, 1};
        vecs[7] = '{0,     12,  9,     -1, 0,  3, 0, 1'b1, 0};

        buildZigzag();
        checkOutput("zigzag_step17", zz[17], 19);

        reset = 1'b1;
        bus.block_valid = 1'b0;
        bus.block_768bits = '0;
        bus.sym_ready = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_block_ready", int'(bus.block_ready), 0);
        checkOutput("reset_sym_valid", int'(bus.sym_valid), 0);
        checkOutput("reset_sym_run", int'(bus.sym_run), 0);
        checkOutput("reset_sym_value", int'(bus.sym_value), 0);
        checkOutput("reset_sym_last", int'(bus.sym_last), 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("ready_after_reset", int'(bus.block_ready), 1);

        for (int i = 0; i < 8; i++) begin
            loadVector(vecs[i]);
            applyStimulus(vecs[i].stall_mode, (i == 0), n_syms, n_zrl, eob_end, model_syms);
            checkOutput($sformatf("vec%0d_symbols", i), n_syms, vecs[i].exp_syms);
            checkOutput($sformatf("vec%0d_zrl", i), n_zrl, vecs[i].exp_zrl);
            checkOutput($sformatf("vec%0d_eob_end", i), int'(eob_end), int'(vecs[i].exp_eob_end));
        end

        for (int b = 0; b < 12; b++) begin
            int density = (b % 3 == 0) ? 40 : 6;
            for (int r = 0; r < 64; r++) begin
                int v = int'($urandom_range(0, 4095));
                if (v >= 2048) v -= 4096;
                coefs[r] = ($urandom_range(0, density - 1) == 0) ? v : 0;
            end
            applyStimulus(1, 1'b0, n_syms, n_zrl, eob_end, model_syms);
            checkOutput($sformatf("rand%0d_symbols", b), n_syms, model_syms);
        end

        // Reset in the middle of the AC scan of a block.
        for (int r = 0; r < 64; r++) coefs[r] = 0;
        coefs[0] = 3;
        @(negedge clock);
        for (int r = 0; r < 64; r++) bus.block_768bits[12*r +: 12] = coefs[r][11:0];
        bus.block_valid = 1'b1;
        @(negedge clock);
        bus.block_valid = 1'b0;
        bus.sym_ready = 1'b1;
        repeat (8) @(negedge clock);
        checkOutput("scan_sym_valid", int'(bus.sym_valid), 0);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checkOutput("midrst_sym_valid", int'(bus.sym_valid), 0);
            checkOutput("midrst_block_ready", int'(bus.block_ready), 0);
        end
        reset = 1'b0;
        bus.sym_ready = 1'b0;
        @(negedge clock);
        checkOutput("midrst_ready_release", int'(bus.block_ready), 1);
        for (int r = 0; r < 64; r++) coefs[r] = 0;
        coefs[0] = 5;
        applyStimulus(0, 1'b0, n_syms, n_zrl, eob_end, model_syms);
        checkOutput("post_reset_symbols", n_syms, 2);
        checkOutput("post_reset_eob", int'(eob_end), 1);

        // Reset while a DC symbol is stalled must drop it.
        @(negedge clock);
        bus.block_valid = 1'b1;
        @(negedge clock);
        bus.block_valid = 1'b0;
        checkOutput("stalled_dc_valid", int'(bus.sym_valid), 1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("dc_reset_sym_valid", int'(bus.sym_valid), 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("dc_reset_ready", int'(bus.block_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jpeg_zigzag_rle.md
# jpeg_zigzag_rle

Zigzag scanner and AC run-length symbolizer for the JPEG encoder. It accepts one quantized 8x8 block of 64 signed 12-bit coefficients, packed as a 768-bit word by the 64x12 data buffer stage directly upstream. It walks the block in JPEG zigzag order and emits a stream of (run, value) symbols, including the DC term, ZRL and EOB markers, to the downstream Huffman coder over a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 12, coefficient width (signed two's complement)
- DEPTH, 64, coefficients per block; fixed at 64

Ports:
- clock  in  1  single clock domain, rising edge
- reset  in  1  synchronous, active-high reset
- block_valid  in  1  block_768bits holds a complete block
- block_ready  out  1  block accepted on the edge where block_valid && block_ready
- block_768bits  in  768  raster coefficient r at bits [12r+11:12r]; r=0 (DC) at the LSBs
- sym_valid  out  1  symbol presented
- sym_ready  in  1  downstream accepts the symbol
- sym_run  out  4  count of preceding zero AC coefficients (0..15)
- sym_value  out  12  coefficient value; 0 for ZRL and EOB
- sym_dc  out  1  symbol is the DC term
- sym_zrl  out  1  ZRL marker (run=15, value=0)
- sym_eob  out  1  EOB marker (run=0, value=0)
- sym_last  out  1  final symbol of the block

## Operation
- States are IDLE, DC, SCAN, EMIT, EOB.
- **IDLE**
  - block_ready=1.
  - On accept, latch all 768 bits and go to DC.
  - The upstream buffer may change after the accept edge.
- **DC**
  - Present sym_dc=1, run=0, value=coef[0].
  - On handshake: idx=1, zrun=0, go to SCAN.
- **SCAN**: examine one coefficient per cycle, c = coef[ZIGZAG[idx]].
  - c==0 and idx<63: zrun++, idx++, stay in SCAN.
  - c==0 and idx==63: go to EOB. Any pending zrun≥16 is discarded; no ZRL is emitted.
  - c!=0 and zrun≥16: load a ZRL symbol, go to EMIT. On handshake, zrun-=16 and return to SCAN at the same idx.
  - c!=0 and zrun<16: load (zrun, c), go to EMIT. On handshake, zrun=0.
    - If idx<63: idx++, back to SCAN.
    - If idx==63: sym_last=1, go to IDLE.
- **EOB**
  - Present sym_eob=1, sym_last=1.
  - On handshake, go to IDLE.
- The zero test compares all 12 bits. A coefficient of -2048 counts as nonzero and is passed through unchanged.
- idx is 6 bits and zrun is 6 bits; neither wraps within a block.
- Every block produces exactly one DC symbol and exactly one symbol with sym_last.

## Timing
- Reset values: state=IDLE, sym_valid=0, all sym_* fields=0, idx=0, zrun=0.
- block_ready=0 while reset is high. block_ready=1 from the first cycle after reset is released.
- All sym_* outputs are registered.
- Latency:
  - DC: sym_valid rises the cycle after the accept edge.
  - Other symbols: presented the cycle after the SCAN cycle that produced them.
- Handshake:
  - While sym_valid && !sym_ready, all sym_* outputs hold stable.
  - sym_valid never drops without a handshake, except on reset.
- Throughput:
  - Zero coefficients cost 1 cycle each.
  - Each emitted symbol costs at least 1 cycle.
  - An all-zero AC block with sym_ready held high: DC at accept+1, EOB valid at accept+65.
- block_ready is low from the accept edge until the cycle after the last-symbol handshake, so there is no overlap between blocks.
- Reset mid-block: the state machine aborts. sym_valid=0 in the cycle after reset is sampled. The partial block is dropped, and the next accepted block encodes from idx 0.

## Structure
- Shared package jpeg_pkg holds:
  - ZIGZAG_TO_RASTER[0:63] constant (0,1,8,16,9,2,3,10,17,24,...,63)
  - state enum
  - ZRL_RUN=15
  - coefficient width constant
- One sub-module, jpeg_zigzag_lut: combinational, 6-bit zigzag index in, 6-bit raster index out, driven from the package table.
- The coefficient mux selects 12 bits from the latched 768-bit word by raster index.

## Test plan
- DC=5, all AC zero, sym_ready high -> DC(0,5) at accept+1, then EOB with sym_last at accept+65. No other symbols.
- Raster coef[1]=3, coef[8]=-2 -> DC(0,0), (0,0x003), (0,0xFFE), EOB(last).
- Only raster coef[19]=7 (zigzag idx 17) -> DC, ZRL(15,0), (0,7), EOB(last).
- Only raster coef[63]=1 -> DC, ZRL, ZRL, ZRL, (14,1) with sym_last. No EOB.
- sym_ready low for 5 cycles on each symbol of the coef[19] block:
  - sym_* stable while stalled
  - block_ready=0 throughout
  - identical symbol sequence
- Reset asserted mid-SCAN -> sym_valid=0 and block_ready=0 during reset, block_ready=1 after release. A following DC=5, all-zero block yields exactly DC, EOB.
